// File: rtl/pipeline_hazard_controller.sv
// Hazard control for a 5-stage pipeline: memory-wait stalls, branch redirects,
// load-use bubbles, and a saturating stall-cycle counter.
module pipeline_hazard_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  id_rs1_address,
    input  logic [4:0]  id_rs2_address,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd_address,
    input  logic        ex_ram_read,
    input  logic        ex_stdin_read_enable,
    input  logic        ex_branch_taken,
    input  logic        ex_mem_request,
    input  logic        mem_ready,
    input  logic        counter_clear,
    output logic        pc_write_enable,
    output logic        if_id_write_enable,
    output logic        id_ex_write_enable,
    output logic        ex_mem_write_enable,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        REDIRECT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        ex_is_load;
    logic        load_use;

    assign ex_is_load = ex_ram_read | ex_stdin_read_enable;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = ex_is_load && (ex_rd_address != 5'd0) &&
                      ((id_rs1_used && (id_rs1_address == ex_rd_address)) ||
                       (id_rs2_used && (id_rs2_address == ex_rd_address)));

    always_comb begin
        pc_write_enable     = 1'b1;
        if_id_write_enable  = 1'b1;
        id_ex_write_enable  = 1'b1;
        ex_mem_write_enable = 1'b1;
        if_id_flush         = 1'b0;
        id_ex_flush         = 1'b0;
        state_d             = state_q;

        case (state_q)
            RUN: begin
                if (ex_mem_request && !mem_ready) begin
                    pc_write_enable     = 1'b0;
                    if_id_write_enable  = 1'b0;
                    id_ex_write_enable  = 1'b0;
                    ex_mem_write_enable = 1'b0;
                    state_d             = MEM_WAIT;
                end else if (ex_branch_taken) begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = REDIRECT;
                end else if (load_use) begin
                    pc_write_enable    = 1'b0;
                    if_id_write_enable = 1'b0;
                    id_ex_flush        = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    pc_write_enable     = 1'b0;
                    if_id_write_enable  = 1'b0;
                    id_ex_write_enable  = 1'b0;
                    ex_mem_write_enable = 1'b0;
                end else begin
                    state_d = RUN;
                end
            end
            REDIRECT: begin
                // the fetch issued from the stale PC is still arriving in IF/ID
                if_id_flush = 1'b1;
                state_d     = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!reset_n) begin
            pc_write_enable     = 1'b0;
            if_id_write_enable  = 1'b0;
            id_ex_write_enable  = 1'b0;
            ex_mem_write_enable = 1'b0;
            if_id_flush         = 1'b0;
            id_ex_flush         = 1'b0;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (counter_clear) begin
            stall_cycles_d = '0;
        end else if (!pc_write_enable && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: expected control vectors are
// queued as stimulus is applied and compared when outputs settle.
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        reset_n;
    logic [4:0]  id_rs1_address, id_rs2_address, ex_rd_address;
    logic        id_rs1_used, id_rs2_used;
    logic        ex_ram_read, ex_stdin_read_enable, ex_branch_taken;
    logic        ex_mem_request, mem_ready, counter_clear;
    logic        pc_write_enable, if_id_write_enable, id_ex_write_enable, ex_mem_write_enable;
    logic        if_id_flush, id_ex_flush;
    logic [15:0] stall_cycles;
    logic [5:0]  outs;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [5:0]  exp_q[$];

    // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush}
    localparam logic [5:0] DEF   = 6'b111100;
    localparam logic [5:0] STALL = 6'b000000;
    localparam logic [5:0] BR    = 6'b111111;
    localparam logic [5:0] REDIR = 6'b111110;
    localparam logic [5:0] LU    = 6'b001101;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ram;
        logic       stdin;
        logic [5:0] exp;
    } lu_vec_t;

    pipeline_hazard_controller dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .id_rs1_address       (id_rs1_address),
        .id_rs2_address       (id_rs2_address),
        .id_rs1_used          (id_rs1_used),
        .id_rs2_used          (id_rs2_used),
        .ex_rd_address        (ex_rd_address),
        .ex_ram_read          (ex_ram_read),
        .ex_stdin_read_enable (ex_stdin_read_enable),
        .ex_branch_taken      (ex_branch_taken),
        .ex_mem_request       (ex_mem_request),
        .mem_ready            (mem_ready),
        .counter_clear        (counter_clear),
        .pc_write_enable      (pc_write_enable),
        .if_id_write_enable   (if_id_write_enable),
        .id_ex_write_enable   (id_ex_write_enable),
        .ex_mem_write_enable  (ex_mem_write_enable),
        .if_id_flush          (if_id_flush),
        .id_ex_flush          (id_ex_flush),
        .stall_cycles         (stall_cycles)
    );

    assign outs = {pc_write_enable, if_id_write_enable, id_ex_write_enable,
                   ex_mem_write_enable, if_id_flush, id_ex_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // code = {mem_request, mem_ready, branch_taken, load_use_setup}
    task automatic drive(input logic [3:0] c);
        ex_mem_request       = c[3];
        mem_ready            = c[2];
        ex_branch_taken      = c[1];
        ex_ram_read          = c[0];
        ex_stdin_read_enable = 1'b0;
        ex_rd_address        = c[0] ? 5'd5 : 5'd0;
        id_rs1_address       = c[0] ? 5'd5 : 5'd0;
        id_rs1_used          = c[0];
        id_rs2_address       = 5'd0;
        id_rs2_used          = 1'b0;
        counter_clear        = 1'b0;
    endtask

    task automatic clear_counter;
        drive(4'b0000);
        counter_clear = 1'b1;
        @(posedge clk); #1;
        counter_clear = 1'b0;
    endtask

    task automatic test_reset;
        drive(4'b0000);
        reset_n = 1'b0;
        #2;
        checks++;
        if (outs !== STALL) begin
            errors++;
            $display("FAIL reset_outs: got %b expected %b", outs, STALL);
        end
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
        end
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(DEF);
        @(negedge clk);
        checks++;
        if (outs !== exp_q[0]) begin
            errors++;
            $display("FAIL reset_release: got %b expected %b", outs, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(posedge clk); #1;
    endtask

    task automatic test_load_use;
        lu_vec_t tbl [8];
        logic [5:0] exp;
        logic [15:0] base;
        tbl[0] = '{5'd5,  5'd5, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, LU};
        tbl[1] = '{5'd5,  5'd5, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, DEF};
        tbl[2] = '{5'd7,  5'd1, 5'd7,  1'b1, 1'b1, 1'b0, 1'b1, LU};
        tbl[3] = '{5'd0,  5'd0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, DEF};
        tbl[4] = '{5'd0,  5'd3, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1, DEF};
        tbl[5] = '{5'd5,  5'd5, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, DEF};
        tbl[6] = '{5'd31, 5'd3, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, LU};
        tbl[7] = '{5'd9,  5'd8, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, DEF};
        clear_counter();
        base = 16'd0;
        for (int i = 0; i < 8; i++) begin
            drive(4'b0000);
            ex_rd_address        = tbl[i].rd;
            id_rs1_address       = tbl[i].rs1;
            id_rs2_address       = tbl[i].rs2;
            id_rs1_used          = tbl[i].u1;
            id_rs2_used          = tbl[i].u2;
            ex_ram_read          = tbl[i].ram;
            ex_stdin_read_enable = tbl[i].stdin;
            exp_q.push_back(tbl[i].exp);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, outs, exp);
            end
            if (exp == LU) base++;
            @(posedge clk); #1;
            checks++;
            if (stall_cycles !== base) begin
                errors++;
                $display("FAIL load_use_stall[%0d]: got %0d expected %0d", i, stall_cycles, base);
            end
        end
    endtask

    task automatic test_mem_wait;
        logic [3:0] stim [6];
        logic [5:0] expv [6];
        logic [5:0] exp;
        stim = '{4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b0000, 4'b1100};
        expv = '{STALL, STALL, STALL, DEF, DEF, DEF};
        clear_counter();
        for (int i = 0; i < 6; i++) begin
            drive(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b expected %b", i, outs, exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles !== 16'd3) begin
            errors++;
            $display("FAIL mem_wait_stall: got %0d expected 3", stall_cycles);
        end
    endtask

    task automatic test_branch;
        logic [3:0] stim [4];
        logic [5:0] expv [4];
        logic [5:0] exp;
        stim = '{4'b0010, 4'b0000, 4'b0000, 4'b0000};
        expv = '{BR, REDIR, DEF, DEF};
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b", i, outs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority;
        logic [3:0] stim [7];
        logic [5:0] expv [7];
        logic [5:0] exp;
        stim = '{4'b1011, 4'b1011, 4'b1100, 4'b0011, 4'b0000, 4'b0001, 4'b0000};
        expv = '{STALL, STALL, DEF, BR, REDIR, LU, DEF};
        clear_counter();
        for (int i = 0; i < 7; i++) begin
            drive(stim[i]);
            exp_q.push_back(expv[i]);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL priority[%0d]: got %b expected %b", i, outs, exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles !== 16'd3) begin
            errors++;
            $display("FAIL priority_stall: got %0d expected 3", stall_cycles);
        end
    endtask

    task automatic test_saturation;
        clear_counter();
        drive(4'b1000);
        repeat (65540) @(posedge clk);
        #1;
        checks++;
        if (stall_cycles !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturate: got %h expected ffff", stall_cycles);
        end
        counter_clear = 1'b1;
        exp_q.push_back(STALL);
        @(negedge clk);
        checks++;
        if (outs !== exp_q[0]) begin
            errors++;
            $display("FAIL clear_stall_outs: got %b expected %b", outs, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(posedge clk); #1;
        counter_clear = 1'b0;
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL clear_during_stall: got %0d expected 0", stall_cycles);
        end
        drive(4'b1100);
        @(posedge clk); #1;
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL clear_release: got %0d expected 0", stall_cycles);
        end
    endtask

    task automatic test_async_reset;
        logic [3:0] pre [2];
        pre = '{4'b1000, 4'b0010};
        for (int i = 0; i < 2; i++) begin
            drive(pre[i]);
            @(posedge clk); #1;
            drive(4'b1000);
            #2 reset_n = 1'b0;
            #1;
            checks++;
            if (outs !== STALL) begin
                errors++;
                $display("FAIL async_reset_outs[%0d]: got %b expected %b", i, outs, STALL);
            end
            checks++;
            if (stall_cycles !== 16'd0) begin
                errors++;
                $display("FAIL async_reset_stall[%0d]: got %0d expected 0", i, stall_cycles);
            end
            drive(4'b0000);
            @(negedge clk);
            reset_n = 1'b1;
            @(posedge clk); #1;
            exp_q.push_back(DEF);
            @(negedge clk);
            checks++;
            if (outs !== exp_q[0]) begin
                errors++;
                $display("FAIL async_reset_after[%0d]: got %b expected %b", i, outs, exp_q[0]);
            end
            void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch();
        test_priority();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports id_rs1_address, id_rs2_address  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL have ports id_rs1_used, id_rs2_used  in  1 each  the ID instruction reads that source.
REQ-005 SHALL have port ex_rd_address  in  5  destination of the instruction in EX.
REQ-006 SHALL have ports ex_ram_read, ex_stdin_read_enable  in  1 each  the EX instruction is a load-type.
REQ-007 SHALL have port ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-008 SHALL have port ex_mem_request  in  1  the EX instruction accesses RAM, stdin or stdout.
REQ-009 SHALL have port mem_ready  in  1  the accessed device completes this cycle.
REQ-010 SHALL have port counter_clear  in  1  synchronous clear of stall_cycles.
REQ-011 SHALL have ports pc_write_enable, if_id_write_enable, id_ex_write_enable, ex_mem_write_enable  out  1 each  stage-register advance enables.
REQ-012 SHALL have ports if_id_flush, id_ex_flush  out  1 each  load a bubble (all controls 0) into that register.
REQ-013 SHALL have port stall_cycles  out  16  saturating count of cycles with pc_write_enable=0.

Function
REQ-014 SHALL implement FSM states RUN, MEM_WAIT, REDIRECT; state register only sequential control element besides stall_cycles.
REQ-015 Default outputs (no condition active, state RUN): all write enables 1, both flushes 0.
REQ-016 load_use = (ex_ram_read|ex_stdin_read_enable) & ex_rd_address!=0 & ((id_rs1_used & rs1==rd) | (id_rs2_used & rs2==rd)); x0 never hazards.
REQ-017 RUN, ex_mem_request=1 and mem_ready=0: all four write enables 0, flushes 0, next state MEM_WAIT.
REQ-018 RUN, ex_mem_request=1 and mem_ready=1: default outputs, stay RUN (zero-wait access).
REQ-019 MEM_WAIT: all write enables 0, flushes 0 while mem_ready=0; on mem_ready=1 all enables 1 that same cycle and next state RUN.
REQ-020 RUN, ex_branch_taken=1 (no memory stall): pc_write_enable=1, if_id_flush=1, id_ex_flush=1, next state REDIRECT.
REQ-021 REDIRECT: if_id_flush=1 (discard the fetch in flight from the old PC), other outputs default, next state RUN unconditionally.
REQ-022 RUN, load_use=1 (no memory stall, no branch): pc_write_enable=0, if_id_write_enable=0, id_ex_flush=1, ex_mem_write_enable=1; one bubble per hazard, stay RUN.
REQ-023 Priority when simultaneous: memory stall > branch redirect > load-use; the lower-priority condition is ignored that cycle.
REQ-024 Flush and write enable asserted together on one register: flush wins (register loads bubble).
REQ-025 stall_cycles increments by 1 each cycle pc_write_enable=0; holds at 16'hFFFF (no wrap).
REQ-026 counter_clear=1 sets stall_cycles to 0 next edge, overriding increment the same cycle.
REQ-027 Outputs other than stall_cycles SHALL be combinational from state and inputs; no extra latency.

Reset
REQ-028 reset_n=0 SHALL immediately force state RUN and stall_cycles 0, independent of clk.
REQ-029 While reset_n=0, all write enables and flushes SHALL be 0.
REQ-030 Reset asserted in MEM_WAIT or REDIRECT SHALL abandon the pending wait/flush; after release state RUN with default outputs.

Verification
REQ-031 Load-use: ex_ram_read=1, ex_rd_address=5, id_rs1_address=5, id_rs1_used=1 -> one cycle pc_we=0, if_id_we=0, id_ex_flush=1; stall_cycles +1.
REQ-032 x0 load: same with rd=rs1=0 -> default outputs, no stall.
REQ-033 Memory wait: ex_mem_request=1, mem_ready low 3 cycles then high -> enables 0 for 3 cycles, 1 on 4th; stall_cycles=3; state RUN after.
REQ-034 Branch: ex_branch_taken=1 one cycle -> if_id_flush=1 two consecutive cycles, id_ex_flush=1 first cycle only.
REQ-035 Priority: ex_mem_request=1, mem_ready=0, ex_branch_taken=1, load_use=1 -> all enables 0, no flush, MEM_WAIT.
REQ-036 Saturation/clear: force 65540 stall cycles -> stall_cycles=16'hFFFF; counter_clear=1 during stall -> 0; async reset in MEM_WAIT -> outputs 0 immediately, RUN after release.
